// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite bus encodings shared by the SRAM slave and its bench.
package ahb3lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE   = 3'b000;
    localparam logic [2:0] HSIZE_HWORD  = 3'b001;
    localparam logic [2:0] HSIZE_WORD   = 3'b010;
    localparam logic [2:0] HSIZE_DWORD  = 3'b011;
    localparam logic [2:0] HSIZE_4WLINE = 3'b100;
    localparam logic [2:0] HSIZE_8WLINE = 3'b101;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/rl_ram_1r1w.sv
// Byte-writable 1R1W RAM with registered read and write-first bypass,
// so a read landing on the edge that commits a write sees the new bytes.
module rl_ram_1r1w #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 32,
    parameter     TECHNOLOGY = "GENERIC",
    parameter     INIT_FILE  = ""
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ABITS-1:0]   waddr,
    input  logic [DBITS/8-1:0] be,
    input  logic [DBITS-1:0]   din,
    input  logic [ABITS-1:0]   raddr,
    output logic [DBITS-1:0]   dout
);
    localparam bit unused_cfg = (TECHNOLOGY != "") || (INIT_FILE != "");

    logic [DBITS-1:0] mem [2**ABITS];
    logic [DBITS-1:0] fwd;

    always_comb begin
        fwd = mem[raddr];
        if (we && waddr == raddr)
            for (int i = 0; i < DBITS/8; i++)
                if (be[i]) fwd[i*8 +: 8] = din[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < DBITS/8; i++)
                if (be[i]) mem[waddr][i*8 +: 8] <= din[i*8 +: 8];
        dout <= fwd;
    end
endmodule

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with read wait states and a one-entry write buffer.
// Define AHB_SRAM_ERRCHK_EN to get ERROR responses for out-of-range/misaligned accesses.
module ahb3lite_sram_ws
    import ahb3lite_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int WAIT_STATES = 0,
    parameter     TECHNOLOGY  = "GENERIC",
    parameter     INIT_FILE   = ""
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int BE  = HDATA_SIZE / 8;
    localparam int BEW = $clog2(BE);
    localparam int AW  = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]            state;
    logic [2:0]            wcnt;
    logic                  accept, err_det, rd_acc, wr_acc;
    logic [AW-1:0]         haddr_idx;
    logic [BE-1:0]         hbe;
    int                    lo;
    logic                  rd_dphase, wr_dphase;
    logic [AW-1:0]         rd_word, wr_word;
    logic [BE-1:0]         wr_be;
    logic                  buf_vld;
    logic [AW-1:0]         buf_addr;
    logic [BE-1:0]         buf_be;
    logic [HDATA_SIZE-1:0] buf_data;
    logic [HDATA_SIZE-1:0] ram_q, rd_merged;
    logic                  unused_in;

    assign unused_in = ^{HBURST, HPROT, HTRANS[0]};
    assign accept    = HSEL & HREADY & HTRANS[1];
    assign haddr_idx = HADDR[BEW +: AW];

    // Lane i is enabled when it sits in the same HSIZE-aligned chunk as the address.
    always_comb begin
        lo  = int'(HADDR & HADDR_SIZE'(BE - 1));
        hbe = '0;
        for (int i = 0; i < BE; i++)
            hbe[i] = ((i >> HSIZE) == (lo >> HSIZE));
    end

`ifdef AHB_SRAM_ERRCHK_EN
    logic [HADDR_SIZE-1:0] haddr_word;
    logic                  misalign;
    assign haddr_word = HADDR >> BEW;
    assign misalign   = (lo & ((1 << HSIZE) - 1)) != 0;
    assign err_det    = accept & ((haddr_word >= HADDR_SIZE'(MEM_DEPTH)) | misalign);
`else
    logic unused_addr;
    assign unused_addr = ^HADDR;
    assign err_det     = 1'b0;
`endif

    assign rd_acc = accept & ~HWRITE & ~err_det;
    assign wr_acc = accept &  HWRITE & ~err_det;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (err_det)
                        state <= ST_ERR1;
                    else if (rd_acc && WAIT_STATES > 0) begin
                        state <= ST_WAIT;
                        wcnt  <= 3'(WAIT_STATES - 1);
                    end else
                        state <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (wcnt == 3'd0) state <= ST_IDLE;
                    else              wcnt  <= wcnt - 3'd1;
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rd_dphase <= 1'b0;
            wr_dphase <= 1'b0;
            rd_word   <= '0;
            wr_word   <= '0;
            wr_be     <= '0;
        end else if (HREADY) begin
            rd_dphase <= rd_acc;
            wr_dphase <= wr_acc;
            if (accept) begin
                rd_word <= haddr_idx;
                wr_word <= haddr_idx;
                wr_be   <= hbe;
            end
        end
    end

    // Each captured entry commits on the following edge; a new write replaces it in the same cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_be   <= '0;
            buf_data <= '0;
        end else begin
            buf_vld <= wr_dphase;
            if (wr_dphase) begin
                buf_addr <= wr_word;
                buf_be   <= wr_be;
                buf_data <= HWDATA;
            end
        end
    end

    // While stalled the held read word is re-read each cycle so buffer commits stay visible.
    rl_ram_1r1w #(
        .ABITS      (AW),
        .DBITS      (HDATA_SIZE),
        .TECHNOLOGY (TECHNOLOGY),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (HCLK),
        .we    (buf_vld & HRESETn),
        .waddr (buf_addr),
        .be    (buf_be),
        .din   (buf_data),
        .raddr (HREADY ? haddr_idx : rd_word),
        .dout  (ram_q)
    );

    always_comb begin
        rd_merged = ram_q;
        if (buf_vld && buf_addr == rd_word)
            for (int i = 0; i < BE; i++)
                if (buf_be[i]) rd_merged[i*8 +: 8] = buf_data[i*8 +: 8];
    end

    assign HRDATA    = rd_dphase ? rd_merged : '0;
    assign HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_ahb3lite_sram_ws;
    import ahb3lite_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [1:0]       hsel, hwrite, hreadyout, hresp;
    logic [1:0][31:0] haddr, hwdata, hrdata;
    logic [1:0][2:0]  hsize;
    logic [1:0][1:0]  htrans;

    int total = 0;
    int bad   = 0;

    ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(HBURST_SINGLE), .HPROT(4'b0011),
        .HTRANS(htrans[0]), .HREADY(hreadyout[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

    ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(HBURST_INCR), .HPROT(4'b0011),
        .HTRANS(htrans[1]), .HREADY(hreadyout[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = HTRANS_IDLE;
        hwrite[d] = 1'b0;
    endtask

    task automatic addr_ph(input int d, input logic w, input logic [31:0] a, input logic [2:0] s);
        hsel[d]   = 1'b1;
        htrans[d] = HTRANS_NONSEQ;
        hwrite[d] = w;
        haddr[d]  = a;
        hsize[d]  = s;
    endtask

    task automatic wait_ready(input int d, output int waits, output bit to);
        waits = 0;
        to    = 1'b0;
        forever begin
            @(negedge HCLK);
            if (hreadyout[d]) break;
            waits++;
            if (waits >= 20) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] data);
        addr_ph(d, 1'b1, a, s);
        tick();
        bus_idle(d);
        hwdata[d] = data;
        tick();
    endtask

    task automatic read(input int d, input logic [31:0] a, input logic [2:0] s,
                        output logic [31:0] data, output logic resp, output int waits, output bit to);
        addr_ph(d, 1'b0, a, s);
        tick();
        bus_idle(d);
        wait_ready(d, waits, to);
        data = hrdata[d];
        resp = hresp[d];
        tick();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        tick();
        tick();
        @(negedge HCLK);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (hreadyout[d] !== 1'b1) begin bad++; $display("FAIL reset_hreadyout[%0d] got=%b exp=1", d, hreadyout[d]); end
            total++;
            if (hresp[d] !== 1'b0) begin bad++; $display("FAIL reset_hresp[%0d] got=%b exp=0", d, hresp[d]); end
            total++;
            if (hrdata[d] !== 32'h0) begin bad++; $display("FAIL reset_hrdata[%0d] got=%h exp=0", d, hrdata[d]); end
        end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        bit low_seen = 1'b0;
        addr_ph(0, 1'b1, 32'h10, HSIZE_WORD);
        tick();
        hwdata[0] = 32'hDEADBEEF;
        addr_ph(0, 1'b0, 32'h10, HSIZE_WORD);
        @(negedge HCLK);
        if (!hreadyout[0]) low_seen = 1'b1;
        tick();
        bus_idle(0);
        @(negedge HCLK);
        if (!hreadyout[0]) low_seen = 1'b1;
        total++;
        if (hrdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_fwd got=%h exp=deadbeef", hrdata[0]); end
        total++;
        if (low_seen !== 1'b0) begin bad++; $display("FAIL wr_rd_noreadylow got=%b exp=0", low_seen); end
        tick();
    endtask

    task automatic test_byte_merge();
        logic [31:0] data;
        logic        resp;
        int          waits;
        bit          to;
        write(0, 32'h10, HSIZE_WORD, 32'h11223344);
        tick();
        addr_ph(0, 1'b1, 32'h13, HSIZE_BYTE);
        tick();
        hwdata[0] = 32'hAA555555;
        addr_ph(0, 1'b0, 32'h10, HSIZE_WORD);
        tick();
        bus_idle(0);
        @(negedge HCLK);
        total++;
        if (hrdata[0] !== 32'hAA223344) begin bad++; $display("FAIL byte_merge got=%h exp=aa223344", hrdata[0]); end
        tick();
        read(0, 32'h10, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (data !== 32'hAA223344) begin bad++; $display("FAIL byte_commit got=%h exp=aa223344", data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        logic        resp;
        int          waits;
        bit          to;
        addr_ph(0, 1'b1, 32'h40, HSIZE_WORD);
        tick();
        hwdata[0] = 32'h01010101;
        addr_ph(0, 1'b1, 32'h44, HSIZE_WORD);
        tick();
        hwdata[0] = 32'h02020202;
        addr_ph(0, 1'b1, 32'h41, HSIZE_BYTE);
        tick();
        hwdata[0] = 32'h00003300;
        bus_idle(0);
        tick();
        tick();
        read(0, 32'h40, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (data !== 32'h01013301) begin bad++; $display("FAIL b2b_word40 got=%h exp=01013301", data); end
        read(0, 32'h44, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (data !== 32'h02020202) begin bad++; $display("FAIL b2b_word44 got=%h exp=02020202", data); end
    endtask

    task automatic test_wait_states();
        logic [31:0] data;
        logic        resp;
        int          waits;
        bit          to;
        write(1, 32'h20, HSIZE_WORD, 32'h12345678);
        tick();
        read(1, 32'h20, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (waits !== 3 || to) begin bad++; $display("FAIL ws3_waits got=%0d exp=3", waits); end
        total++;
        if (data !== 32'h12345678) begin bad++; $display("FAIL ws3_data got=%h exp=12345678", data); end
        total++;
        if (resp !== HRESP_OKAY) begin bad++; $display("FAIL ws3_resp got=%b exp=0", resp); end
        // write immediately followed by a stalled read of the same word
        addr_ph(1, 1'b1, 32'h24, HSIZE_WORD);
        tick();
        hwdata[1] = 32'hA5A5A5A5;
        addr_ph(1, 1'b0, 32'h24, HSIZE_WORD);
        tick();
        bus_idle(1);
        wait_ready(1, waits, to);
        total++;
        if (hrdata[1] !== 32'hA5A5A5A5 || waits !== 3 || to) begin
            bad++; $display("FAIL ws3_fwd got=%h/%0d exp=a5a5a5a5/3", hrdata[1], waits);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [31:0] data;
        logic        resp;
        int          waits;
        bit          to;
        write(1, 32'h30, HSIZE_WORD, 32'h0BADF00D);
        tick();
        addr_ph(1, 1'b0, 32'h20, HSIZE_WORD);
        tick();
        bus_idle(1);
        tick();
        HRESETn = 1'b0;
        tick();
        @(negedge HCLK);
        total++;
        if (hreadyout[1] !== 1'b1) begin bad++; $display("FAIL abort_hreadyout got=%b exp=1", hreadyout[1]); end
        total++;
        if (hrdata[1] !== 32'h0) begin bad++; $display("FAIL abort_hrdata got=%h exp=0", hrdata[1]); end
        HRESETn = 1'b1;
        tick();
        @(negedge HCLK);
        total++;
        if (hreadyout[1] !== 1'b1 || hresp[1] !== 1'b0) begin
            bad++; $display("FAIL abort_idle got=%b%b exp=10", hreadyout[1], hresp[1]);
        end
        tick();
        // reset lands on the edge that would capture the write data
        addr_ph(1, 1'b1, 32'h30, HSIZE_WORD);
        tick();
        bus_idle(1);
        hwdata[1] = 32'hCAFEF00D;
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        tick();
        read(1, 32'h30, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (data !== 32'h0BADF00D) begin bad++; $display("FAIL abort_nowrite got=%h exp=0badf00d", data); end
    endtask

    task automatic test_errchk();
        logic [31:0] data;
        logic        resp;
        int          waits;
        bit          to;
        write(0, 32'h0, HSIZE_WORD, 32'h5A5A0000);
        tick();
`ifdef AHB_SRAM_ERRCHK_EN
        addr_ph(0, 1'b1, 32'h400, HSIZE_WORD);
        tick();
        bus_idle(0);
        hwdata[0] = 32'hFFFFFFFF;
        @(negedge HCLK);
        total++;
        if ({hreadyout[0], hresp[0]} !== 2'b01) begin bad++; $display("FAIL oor_err1 got=%b%b exp=01", hreadyout[0], hresp[0]); end
        tick();
        @(negedge HCLK);
        total++;
        if ({hreadyout[0], hresp[0]} !== 2'b11) begin bad++; $display("FAIL oor_err2 got=%b%b exp=11", hreadyout[0], hresp[0]); end
        tick();
        @(negedge HCLK);
        total++;
        if ({hreadyout[0], hresp[0]} !== 2'b10) begin bad++; $display("FAIL oor_idle got=%b%b exp=10", hreadyout[0], hresp[0]); end
        tick();
        read(0, 32'h0, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (data !== 32'h5A5A0000) begin bad++; $display("FAIL oor_nowrite got=%h exp=5a5a0000", data); end
        addr_ph(0, 1'b0, 32'h02, HSIZE_WORD);
        tick();
        bus_idle(0);
        @(negedge HCLK);
        total++;
        if ({hreadyout[0], hresp[0]} !== 2'b01) begin bad++; $display("FAIL mis_err1 got=%b%b exp=01", hreadyout[0], hresp[0]); end
        tick();
        @(negedge HCLK);
        total++;
        if ({hreadyout[0], hresp[0]} !== 2'b11) begin bad++; $display("FAIL mis_err2 got=%b%b exp=11", hreadyout[0], hresp[0]); end
        tick();
`else
        read(0, 32'h02, HSIZE_WORD, data, resp, waits, to);
        total++;
        if (resp !== HRESP_OKAY || waits !== 0 || to) begin
            bad++; $display("FAIL mis_okay got=%b/%0d exp=0/0", resp, waits);
        end
        total++;
        if (data !== 32'h5A5A0000) begin bad++; $display("FAIL mis_data got=%h exp=5a5a0000", data); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            haddr[d]  = '0;
            hwdata[d] = '0;
            hsize[d]  = HSIZE_WORD;
        end
        test_reset();
        test_write_read();
        test_byte_merge();
        test_back_to_back();
        test_wait_states();
        test_reset_abort();
        test_errchk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
